// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit:
// FSM states, operation encoding and default iteration count.
package mult_div_ctrl_pkg;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPrep  = 3'd1,
    StIter  = 3'd2,
    StFixup = 3'd3,
    StDone  = 3'd4
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // Unsigned magnitude of a two's-complement word; 0x80000000 maps to 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl.sv
// Iterative signed MULT/DIV unit: one shift-add or restoring shift-subtract step
// per cycle, sign fixup at the end, results held in HI/LO.
module mult_div_ctrl #(
  parameter int unsigned ITER_COUNT = mult_div_ctrl_pkg::ITER_COUNT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import mult_div_ctrl_pkg::*;

  localparam int unsigned CntW = $clog2(ITER_COUNT + 1);

  state_e          state_q, state_d;
  op_e             op_q;
  logic [31:0]     a_q, b_q;
  logic [31:0]     mag_a_q, mag_b_q;
  logic            qneg_q, rneg_q;
  logic [63:0]     acc_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     hi_q, lo_q;
  logic            done_q, div_zero_q;

  logic            last_iter;
  logic            div_by_zero;
  logic [32:0]     add_sum, sub_diff;
  logic [63:0]     acc_step;
  logic [63:0]     prod_fix;
  logic [31:0]     hi_fix, lo_fix;

  assign last_iter   = (cnt_q == CntW'(ITER_COUNT - 1));
  assign div_by_zero = (op_q == OP_DIV) && (b_q == 32'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StPrep;
      StPrep:  state_d = div_by_zero ? StDone : StIter;
      StIter:  if (last_iter) state_d = StFixup;
      StFixup: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // MULT keeps the multiplier in acc[31:0] and the partial product above it;
  // DIV keeps the partial remainder in acc[63:32] and shifts quotient bits in.
  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    sub_diff = acc_q[63:31] - {1'b0, mag_b_q};
    if (op_q == OP_MULT) begin
      acc_step = {add_sum, acc_q[31:1]};
    end else if (sub_diff[32]) begin
      acc_step = {acc_q[62:0], 1'b0};
    end else begin
      acc_step = {sub_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  always_comb begin
    prod_fix = qneg_q ? (~acc_q + 64'd1) : acc_q;
    if (op_q == OP_MULT) begin
      hi_fix = prod_fix[63:32];
      lo_fix = prod_fix[31:0];
    end else begin
      hi_fix = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
      lo_fix = qneg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= OP_MULT;
      a_q        <= '0;
      b_q        <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= (state_q == StDone);
      div_zero_q <= (state_q == StDone) && div_by_zero;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q <= op_e'(op);
            a_q  <= rs_val;
            b_q  <= rt_val;
          end
        end
        StPrep: begin
          mag_a_q <= abs32(a_q);
          mag_b_q <= abs32(b_q);
          qneg_q  <= a_q[31] ^ b_q[31];
          rneg_q  <= a_q[31];
          cnt_q   <= '0;
          acc_q   <= {32'd0, (op_q == OP_MULT) ? abs32(b_q) : abs32(a_q)};
        end
        StIter: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
        end
        StFixup: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
